// File: rtl/rv32_multicycle_core.sv
// rv32_multicycle_core
// Multi-cycle RV32I/RV32E integer core. Each instruction goes through FETCH,
// EXEC and, for loads/stores, MEM. The instruction and data ports use a
// req/ready handshake, so wait-stated memories are supported. Faults (illegal
// encodings, out-of-range register indices, misaligned targets or data
// addresses) park the core in TRAP until reset.
//
// Optional feature macro: RV_COUNTERS_EN. When it is defined, the core adds
// 64-bit cycle/instret counters that CSRRS with rs1=x0 can read. When it is
// undefined, every SYSTEM opcode traps.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req/addr/ready/rdata instruction fetch handshake (word aligned)
//   dmem_req/we/be/addr/wdata data access request (held until dmem_ready)
//   dmem_ready/rdata          data access completion / load word
//   exception                 sticky trap flag
//   retire                    one-cycle pulse per retired instruction
module rv32_multicycle_core #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            exception,
  output logic            retire
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("rv32_multicycle_core: XLEN must be 32");
  end
  if (NREGS != 32 && NREGS != 16) begin : g_bad_nregs
    $error("rv32_multicycle_core: NREGS must be 16 or 32");
  end

  localparam int unsigned AW = (NREGS == 16) ? 4 : 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_TRAP = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, ir_q, ea_q;
  logic [31:0] regs_q [NREGS];

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_v, rs2_v, pc4;

  assign opc   = ir_q[6:0];
  assign f3    = ir_q[14:12];
  assign f7    = ir_q[31:25];
  assign rd    = ir_q[11:7];
  assign rs1   = ir_q[19:15];
  assign rs2   = ir_q[24:20];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'h000};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  // x0 is never written, so entry 0 always reads back as zero
  assign rs1_v = regs_q[rs1[AW-1:0]];
  assign rs2_v = regs_q[rs2[AW-1:0]];
  assign pc4   = pc_q + 32'd4;

`ifdef RV_COUNTERS_EN
  logic [63:0] cycle_q, instret_q;
`endif

  logic [31:0] alu_b_s, alu_s, wb_val_s, target_s, ea_s, ld_sh_s, ld_val_s, st_data_s, rf_wdata_s;
  logic        use_rs1_s, use_rs2_s, use_rd_s, illegal_s, is_mem_s, misalign_s, bad_idx_s;
  logic        exec_trap_s, rf_we_s;
  logic [3:0]  be_s;

  // ALU shared by OP and OP_IMM; only OP may subtract
  always_comb begin
    alu_b_s = (opc == OPC_OP) ? rs2_v : imm_i;
    case (f3)
      3'b000:  alu_s = (opc == OPC_OP && f7[5]) ? rs1_v - alu_b_s : rs1_v + alu_b_s;
      3'b001:  alu_s = rs1_v << alu_b_s[4:0];
      3'b010:  alu_s = {31'd0, $signed(rs1_v) < $signed(alu_b_s)};
      3'b011:  alu_s = {31'd0, rs1_v < alu_b_s};
      3'b100:  alu_s = rs1_v ^ alu_b_s;
      3'b101:  alu_s = f7[5] ? 32'($signed(rs1_v) >>> alu_b_s[4:0]) : rs1_v >> alu_b_s[4:0];
      3'b110:  alu_s = rs1_v | alu_b_s;
      default: alu_s = rs1_v & alu_b_s;
    endcase
  end

  // Instruction decode: writeback value, next pc, operand usage and trap causes
  always_comb begin
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    use_rd_s  = 1'b0;
    illegal_s = 1'b0;
    is_mem_s  = 1'b0;
    wb_val_s  = alu_s;
    target_s  = pc4;
    ea_s      = rs1_v + ((opc == OPC_STORE) ? imm_s : imm_i);
    case (opc)
      OPC_LUI:   begin use_rd_s = 1'b1; wb_val_s = imm_u; end
      OPC_AUIPC: begin use_rd_s = 1'b1; wb_val_s = pc_q + imm_u; end
      OPC_JAL:   begin use_rd_s = 1'b1; wb_val_s = pc4; target_s = pc_q + imm_j; end
      OPC_JALR: begin
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        wb_val_s  = pc4;
        target_s  = (rs1_v + imm_i) & 32'hFFFF_FFFE;
        illegal_s = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        case (f3)
          3'b000:  target_s = (rs1_v == rs2_v) ? pc_q + imm_b : pc4;
          3'b001:  target_s = (rs1_v != rs2_v) ? pc_q + imm_b : pc4;
          3'b100:  target_s = ($signed(rs1_v) <  $signed(rs2_v)) ? pc_q + imm_b : pc4;
          3'b101:  target_s = ($signed(rs1_v) >= $signed(rs2_v)) ? pc_q + imm_b : pc4;
          3'b110:  target_s = (rs1_v <  rs2_v) ? pc_q + imm_b : pc4;
          3'b111:  target_s = (rs1_v >= rs2_v) ? pc_q + imm_b : pc4;
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        is_mem_s  = 1'b1;
        illegal_s = (f3[1:0] == 2'b11) || (f3 == 3'b110);
      end
      OPC_STORE: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        is_mem_s  = 1'b1;
        illegal_s = f3[2] || (f3[1:0] == 2'b11);
      end
      OPC_OPIMM: begin
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        illegal_s = (f3 == 3'b001 && f7 != 7'h00) ||
                    (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPC_OP: begin
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        illegal_s = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_FENCE: illegal_s = 1'b0;
`ifdef RV_COUNTERS_EN
      OPC_SYSTEM: begin
        use_rd_s = 1'b1;
        if (f3 == 3'b010 && rs1 == 5'd0) begin
          case (ir_q[31:20])
            12'hC00: wb_val_s = cycle_q[31:0];
            12'hC80: wb_val_s = cycle_q[63:32];
            12'hC02: wb_val_s = instret_q[31:0];
            12'hC82: wb_val_s = instret_q[63:32];
            default: illegal_s = 1'b1;
          endcase
        end else begin
          illegal_s = 1'b1;
        end
      end
`endif
      default: illegal_s = 1'b1;
    endcase
    misalign_s  = (f3[1:0] == 2'b01 && ea_s[0]) || (f3[1:0] == 2'b10 && ea_s[1:0] != 2'b00);
    bad_idx_s   = (NREGS == 16) && ((use_rs1_s && rs1[4]) || (use_rs2_s && rs2[4]) || (use_rd_s && rd[4]));
    exec_trap_s = illegal_s || bad_idx_s || (target_s[1:0] != 2'b00) || (is_mem_s && misalign_s);
  end

  // Byte-lane enables, replicated store data and extended load data for MEM
  always_comb begin
    case (f3[1:0])
      2'b00:   begin be_s = 4'b0001 << ea_q[1:0]; st_data_s = {4{rs2_v[7:0]}}; end
      2'b01:   begin be_s = 4'b0011 << ea_q[1:0]; st_data_s = {2{rs2_v[15:0]}}; end
      default: begin be_s = 4'b1111;              st_data_s = rs2_v; end
    endcase
    ld_sh_s = dmem_rdata >> {ea_q[1:0], 3'b000};
    case (f3)
      3'b000:  ld_val_s = {{24{ld_sh_s[7]}}, ld_sh_s[7:0]};
      3'b001:  ld_val_s = {{16{ld_sh_s[15]}}, ld_sh_s[15:0]};
      3'b100:  ld_val_s = {24'd0, ld_sh_s[7:0]};
      3'b101:  ld_val_s = {16'd0, ld_sh_s[15:0]};
      default: ld_val_s = dmem_rdata;
    endcase
  end

  // Register-file write port: EXEC results, or load data on the ready cycle
  always_comb begin
    rf_we_s    = 1'b0;
    rf_wdata_s = wb_val_s;
    if (state_q == S_EXEC && !exec_trap_s && !is_mem_s && use_rd_s) begin
      rf_we_s = 1'b1;
    end else if (state_q == S_MEM && dmem_ready && !ir_q[5]) begin
      rf_we_s    = 1'b1;
      rf_wdata_s = ld_val_s;
    end else begin
      rf_we_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = imem_ready ? S_EXEC : S_FETCH;
      S_EXEC:  state_d = exec_trap_s ? S_TRAP : (is_mem_s ? S_MEM : S_FETCH);
      S_MEM:   state_d = dmem_ready ? S_FETCH : S_MEM;
      default: state_d = S_TRAP;
    endcase
  end

  // FSM outputs; bus fields are zero whenever no data request is active
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = pc_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    exception  = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: imem_req = !rst;
      S_EXEC:  retire   = !exec_trap_s && !is_mem_s;
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = ir_q[5];
        dmem_be    = be_s;
        dmem_addr  = {ea_q[31:2], 2'b00};
        dmem_wdata = st_data_s;
        retire     = dmem_ready;
      end
      default: exception = 1'b1;
    endcase
  end

  // Architectural state: pc, instruction register, effective address, registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      ir_q <= 32'd0;
      ea_q <= 32'd0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'd0;
    end else begin
      if (state_q == S_FETCH && imem_ready) ir_q <= imem_rdata;
      if (state_q == S_EXEC && !exec_trap_s) begin
        if (is_mem_s) ea_q <= ea_s;
        else          pc_q <= target_s;
      end
      if (state_q == S_MEM && dmem_ready) pc_q <= pc4;
      if (rf_we_s && rd != 5'd0) regs_q[rd[AW-1:0]] <= rf_wdata_s;
    end
  end

`ifdef RV_COUNTERS_EN
  // Free-running cycle counter and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (retire) instret_q <= instret_q + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Directed bench for rv32_multicycle_core: ALU sequence, fetch wait states,
// byte-lane loads/stores, misaligned trap, branches/jumps, reset during a
// data request, and RV32E register-index trap on a second instance.
module tb_rv32_multicycle_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, exception, retire;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        e_imem_req, e_dmem_req, e_dmem_we, e_exception, e_retire;
  logic [31:0] e_imem_addr, e_dmem_addr, e_dmem_wdata;
  logic [3:0]  e_dmem_be;

  logic [31:0] prog [64];
  int imem_wait = 0, dmem_wait = 0, imem_cnt = 0, dmem_cnt = 0;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  // wait-stated memory models: ready once the request has waited long enough
  assign imem_ready = imem_req && (imem_cnt >= imem_wait);
  assign imem_rdata = prog[imem_addr[7:2]];
  assign dmem_ready = dmem_req && (dmem_cnt >= dmem_wait);
  assign dmem_rdata = 32'h8081_82F3;

  always @(posedge clk) begin
    imem_cnt <= (imem_req && !imem_ready) ? imem_cnt + 1 : 0;
    dmem_cnt <= (dmem_req && !dmem_ready) ? dmem_cnt + 1 : 0;
  end

  rv32_multicycle_core dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .exception(exception), .retire(retire)
  );

  // RV32E instance always fetching ADD x17,x1,x2
  rv32_multicycle_core #(.NREGS(16)) dut_e (
    .clk(clk), .rst(rst),
    .imem_req(e_imem_req), .imem_addr(e_imem_addr), .imem_ready(e_imem_req), .imem_rdata(32'h0020_88B3),
    .dmem_req(e_dmem_req), .dmem_we(e_dmem_we), .dmem_be(e_dmem_be), .dmem_addr(e_dmem_addr),
    .dmem_wdata(e_dmem_wdata), .dmem_ready(1'b0), .dmem_rdata(32'h0000_0000),
    .exception(e_exception), .retire(e_retire)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // hold reset for two clocks, release on a negedge, land in cycle 1
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0013;
  endtask

  logic [31:0] br_addr [7];

  initial begin
    rst = 1'b1;
    clear_prog();
    prog[0] = 32'h0050_0093;  // ADDI x1,x0,5
    prog[1] = 32'hFF90_8113;  // ADDI x2,x1,-7
    prog[2] = 32'h4020_81B3;  // SUB  x3,x1,x2
    prog[3] = 32'h4011_5213;  // SRAI x4,x2,1
    step(2);
    check1("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 32'h0000_0000);
    check1("rst_dmem_req", dmem_req, 1'b0);
    check1("rst_exception", exception, 1'b0);
    check1("rst_retire", retire, 1'b0);

    // ---- zero-wait ALU sequence ----
    do_reset();
    check1("c1_imem_req", imem_req, 1'b1);
    check("c1_imem_addr", imem_addr, 32'h0000_0000);
    check1("c1_retire", retire, 1'b0);
    step(1);
    check1("c2_retire", retire, 1'b1);
    check1("e_c2_retire", e_retire, 1'b0);
    step(1);
    check1("c3_retire", retire, 1'b0);
    check("c3_imem_addr", imem_addr, 32'h0000_0004);
    check("x1_addi", dut.regs_q[1], 32'h0000_0005);
    check1("e_exception", e_exception, 1'b1);
    check1("e_imem_req", e_imem_req, 1'b0);
    check("e_pc_frozen", e_imem_addr, 32'h0000_0000);
    check("e_dmem_idle", e_dmem_addr | e_dmem_wdata | {27'd0, e_dmem_we, e_dmem_be}, 32'h0000_0000);
    check1("e_dmem_req", e_dmem_req, 1'b0);
    step(1);
    check1("c4_retire", retire, 1'b1);
    step(1);
    check("c5_imem_addr", imem_addr, 32'h0000_0008);
    check("x2_addi_neg", dut.regs_q[2], 32'hFFFF_FFFE);
    step(4);
    check("x3_sub", dut.regs_q[3], 32'h0000_0007);
    check("x4_srai", dut.regs_q[4], 32'hFFFF_FFFF);
    check("c9_imem_addr", imem_addr, 32'h0000_0010);

    // ---- fetch with 3 wait cycles ----
    imem_wait = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check1("stall_imem_req", imem_req, 1'b1);
      check("stall_imem_addr", imem_addr, 32'h0000_0000);
      check1("stall_retire", retire, 1'b0);
      step(1);
    end
    check1("ready_cycle_retire", retire, 1'b0);
    step(1);
    check1("wait_retire", retire, 1'b1);
    step(1);
    check1("wait_retire_once", retire, 1'b0);
    check("wait_next_addr", imem_addr, 32'h0000_0004);
    imem_wait = 0;

    // ---- loads / stores with byte lanes, then misaligned LW ----
    clear_prog();
    prog[0] = 32'h1000_0093;  // ADDI x1,x0,0x100
    prog[1] = 32'h0010_8103;  // LB   x2,1(x1)
    prog[2] = 32'h0020_D183;  // LHU  x3,2(x1)
    prog[3] = 32'h0010_81A3;  // SB   x1,3(x1)
    prog[4] = 32'h0010_9123;  // SH   x1,2(x1)
    prog[5] = 32'h0020_A103;  // LW   x2,2(x1)
    dmem_wait = 1;
    do_reset();
    step(4);
    check1("lb_req", dmem_req, 1'b1);
    check("lb_addr", dmem_addr, 32'h0000_0100);
    check("lb_be", {28'd0, dmem_be}, 32'h0000_0002);
    check1("lb_we", dmem_we, 1'b0);
    check1("lb_wait_retire", retire, 1'b0);
    step(1);
    check1("lb_req_held", dmem_req, 1'b1);
    check("lb_addr_held", dmem_addr, 32'h0000_0100);
    check("lb_be_held", {28'd0, dmem_be}, 32'h0000_0002);
    check1("lb_retire", retire, 1'b1);
    dmem_wait = 0;
    step(1);
    check("lb_x2", dut.regs_q[2], 32'hFFFF_FF82);
    check("lb_next_addr", imem_addr, 32'h0000_0008);
    step(2);
    check("lhu_be", {28'd0, dmem_be}, 32'h0000_000C);
    check1("lhu_retire", retire, 1'b1);
    step(1);
    check("lhu_x3", dut.regs_q[3], 32'h0000_8081);
    step(2);
    check1("sb_we", dmem_we, 1'b1);
    check("sb_be", {28'd0, dmem_be}, 32'h0000_0008);
    check("sb_wdata", dmem_wdata, 32'h0000_0000);
    check("sb_addr", dmem_addr, 32'h0000_0100);
    step(3);
    check1("sh_we", dmem_we, 1'b1);
    check("sh_be", {28'd0, dmem_be}, 32'h0000_000C);
    check("sh_wdata", dmem_wdata, 32'h0100_0100);
    step(1);
    check("lw_fetch_addr", imem_addr, 32'h0000_0014);
    step(1);
    check1("lw_exec_retire", retire, 1'b0);
    check1("lw_exec_dmem_req", dmem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check1("trap_exception", exception, 1'b1);
      check1("trap_dmem_req", dmem_req, 1'b0);
      check1("trap_imem_req", imem_req, 1'b0);
      check("trap_pc", imem_addr, 32'h0000_0014);
    end
    check("trap_x2_kept", dut.regs_q[2], 32'hFFFF_FF82);

    // ---- reset while a data request is pending ----
    dmem_wait = 20;
    do_reset();
    step(4);
    check1("pend_dmem_req", dmem_req, 1'b1);
    #1 rst = 1'b1;
    #1;
    check1("rst_drops_dmem_req", dmem_req, 1'b0);
    check1("rst_drops_imem_req", imem_req, 1'b0);
    check("rst_pc", imem_addr, 32'h0000_0000);
    check("rst_x1_cleared", dut.regs_q[1], 32'h0000_0000);
    step(1);
    rst = 1'b0;
    dmem_wait = 0;
    #1;
    check1("post_rst_imem_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, 32'h0000_0000);
    step(1);
    check1("post_rst_retire", retire, 1'b1);
    check1("post_rst_no_exc", exception, 1'b0);

    // ---- branches and jump ----
    clear_prog();
    prog[0] = 32'hFFF0_0093;  // ADDI x1,x0,-1
    prog[1] = 32'h0010_0113;  // ADDI x2,x0,1
    prog[2] = 32'h0020_C663;  // 0x08 BLT  x1,x2,+12 -> 0x14
    prog[4] = 32'hFE00_0CE3;  // 0x10 BEQ  x0,x0,-8  -> 0x08
    prog[5] = 32'h0020_E663;  // 0x14 BLTU x1,x2,+12 -> not taken
    prog[6] = 32'hFF9F_F06F;  // 0x18 JAL  x0,-8     -> 0x10
    br_addr[0] = 32'h00; br_addr[1] = 32'h04; br_addr[2] = 32'h08; br_addr[3] = 32'h14;
    br_addr[4] = 32'h18; br_addr[5] = 32'h10; br_addr[6] = 32'h08;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      check("branch_fetch_addr", imem_addr, br_addr[i]);
      step(2);
    end
    check1("branch_no_exc", exception, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
